// File: rtl/rf_arb_pkg.sv
// -----------------------------------------------------------------------------
// rf_arb_pkg
// Shared constants and types for the register-file write arbiter slice.
//   NUM_REQ            number of writeback requesters (ALU = 0, LSU = 1)
//   req_idx_t          requester index type
//   CNT_WIDTH_DEFAULT  default width of the per-requester stall counters
// -----------------------------------------------------------------------------
package rf_arb_pkg;

    localparam int NUM_REQ           = 2;
    localparam int CNT_WIDTH_DEFAULT = 8;

    typedef logic req_idx_t;

    localparam req_idx_t REQ_ALU = 1'b0;
    localparam req_idx_t REQ_LSU = 1'b1;

endpackage : rf_arb_pkg

// File: rtl/rf_write_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant generator with its last_grant history flop.
// Ports:
//   clk_i         clock
//   rst_n_i       synchronous active-low reset; forces grant_o to 0 while low
//   valid_i       per-requester valid
//   grant_o       one-hot (or zero) grant, combinational from valid_i/last_grant
//   last_grant_o  index of the most recently granted requester
// -----------------------------------------------------------------------------
module rr_arb2
    import rf_arb_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_REQ-1:0] valid_i,
    output logic [NUM_REQ-1:0] grant_o,
    output req_idx_t           last_grant_o
);

    req_idx_t last_grant_q;

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_o = '0;
        if (rst_n_i) begin
            unique case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                // Tie: the requester that did not win last time goes now.
                2'b11:   grant_o = (last_grant_q == REQ_LSU) ? 2'b01 : 2'b10;
                default: grant_o = '0;
            endcase
        end
    end

    // Reset to LSU so the ALU wins the first tie after reset.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process ordering.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            last_grant_q <= REQ_LSU;
        end else if (|grant_o) begin
            last_grant_q <= req_idx_t'(grant_o[1]);
        end
    end

    assign last_grant_o = last_grant_q;

endmodule : rr_arb2

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
// Shares the single register-file write port between the ALU (requester 0)
// and the LSU (requester 1). Valid/ready handshake, round-robin on ties,
// registered write port, saturating per-requester stall counters.
// Ports:
//   clk_i, rst_n_i                    clock, synchronous active-low reset
//   reqN_valid_i/addr_i/data_i        requester N write request
//   reqN_ready_o                      requester N accepted this cycle (comb)
//   rf_wen_o/rf_waddr_o/rf_wdata_o    registered register-file write port
//   stall0_cnt_o/stall1_cnt_o         cycles each requester waited
//   stall_clr_i                       synchronous clear of both counters
// -----------------------------------------------------------------------------
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int AWIDTH    = 5,
    parameter int DWIDTH    = 32,
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 req0_valid_i,
    output logic                 req0_ready_o,
    input  logic [AWIDTH-1:0]    req0_addr_i,
    input  logic [DWIDTH-1:0]    req0_data_i,
    input  logic                 req1_valid_i,
    output logic                 req1_ready_o,
    input  logic [AWIDTH-1:0]    req1_addr_i,
    input  logic [DWIDTH-1:0]    req1_data_i,
    output logic                 rf_wen_o,
    output logic [AWIDTH-1:0]    rf_waddr_o,
    output logic [DWIDTH-1:0]    rf_wdata_o,
    output logic [CNT_WIDTH-1:0] stall0_cnt_o,
    output logic [CNT_WIDTH-1:0] stall1_cnt_o,
    input  logic                 stall_clr_i
);

    logic [NUM_REQ-1:0]   valid;
    logic [NUM_REQ-1:0]   grant;
    req_idx_t             last_grant;
    logic                 transfer;
    logic [AWIDTH-1:0]    sel_addr;
    logic [DWIDTH-1:0]    sel_data;
    logic [CNT_WIDTH-1:0] stall_cnt_q [NUM_REQ];

    assign valid = {req1_valid_i, req0_valid_i};

    rr_arb2 u_arb (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .valid_i      (valid),
        .grant_o      (grant),
        .last_grant_o (last_grant)
    );

    assign req0_ready_o = grant[0];
    assign req1_ready_o = grant[1];
    assign transfer     = |grant;

    // Grant is one-hot when present, so grant[1] alone selects the winner.
    assign sel_addr = grant[1] ? req1_addr_i : req0_addr_i;
    assign sel_data = grant[1] ? req1_data_i : req0_data_i;

    // Writes to x0 are acknowledged but never raise the write enable.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rf_wen_o   <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else if (transfer) begin
            rf_wen_o   <= (sel_addr != '0);
            rf_waddr_o <= sel_addr;
            rf_wdata_o <= sel_data;
        end else begin
            rf_wen_o   <= 1'b0;
        end
    end

    // Clear beats increment; counters stop at all-ones instead of wrapping.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst_n_i || stall_clr_i) begin
                stall_cnt_q[i] <= '0;
            end else if (valid[i] && !grant[i] && (stall_cnt_q[i] != '1)) begin
                stall_cnt_q[i] <= stall_cnt_q[i] + 1'b1;
            end
        end
    end

    assign stall0_cnt_o = stall_cnt_q[0];
    assign stall1_cnt_o = stall_cnt_q[1];

endmodule : rf_write_arbiter

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
// Directed self-checking bench for rf_write_arbiter. Inputs change 1 ns after
// a rising edge; combinational readies are sampled 2 ns after the edge,
// registered outputs 1 ns after the edge that captured them.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

    localparam int AWIDTH    = 5;
    localparam int DWIDTH    = 32;
    localparam int CNT_WIDTH = 8;

    logic                 clk_i = 1'b0;
    logic                 rst_n_i;
    logic                 req0_valid_i, req1_valid_i;
    logic                 req0_ready_o, req1_ready_o;
    logic [AWIDTH-1:0]    req0_addr_i, req1_addr_i;
    logic [DWIDTH-1:0]    req0_data_i, req1_data_i;
    logic                 rf_wen_o;
    logic [AWIDTH-1:0]    rf_waddr_o;
    logic [DWIDTH-1:0]    rf_wdata_o;
    logic [CNT_WIDTH-1:0] stall0_cnt_o, stall1_cnt_o;
    logic                 stall_clr_i;

    logic [DWIDTH-1:0]    rf_model [32];
    int                   n_cmp = 0;
    int                   n_err = 0;

    always #5 clk_i = ~clk_i;

    rf_write_arbiter #(
        .AWIDTH    (AWIDTH),
        .DWIDTH    (DWIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_addr_i  (req0_addr_i),
        .req0_data_i  (req0_data_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_addr_i  (req1_addr_i),
        .req1_data_i  (req1_data_i),
        .rf_wen_o     (rf_wen_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .stall0_cnt_o (stall0_cnt_o),
        .stall1_cnt_o (stall1_cnt_o),
        .stall_clr_i  (stall_clr_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Register-file model: commits whatever the write port shows this cycle.
    task automatic commit_rf();
        if (rf_wen_o) rf_model[rf_waddr_o] = rf_wdata_o;
    endtask

    task automatic drive(input logic v0, input logic [AWIDTH-1:0] a0, input logic [DWIDTH-1:0] d0,
                         input logic v1, input logic [AWIDTH-1:0] a1, input logic [DWIDTH-1:0] d1);
        req0_valid_i = v0; req0_addr_i = a0; req0_data_i = d0;
        req1_valid_i = v1; req1_addr_i = a1; req1_data_i = d1;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Expected tie winners starting from last_grant = 1.
    logic [3:0] exp_grant_seq;

    initial begin
        foreach (rf_model[i]) rf_model[i] = '0;
        stall_clr_i = 1'b0;
        rst_n_i     = 1'b0;
        drive(1'b1, 5'd3, 32'h3333, 1'b1, 5'd4, 32'h4444);

        // ---- Reset: readies forced low even with both valid ----
        tick(); tick();
        settle();
        check("rst_ready0", req0_ready_o, 0);
        check("rst_ready1", req1_ready_o, 0);
        check("rst_wen",    rf_wen_o, 0);
        check("rst_waddr",  rf_waddr_o, 0);
        check("rst_wdata",  rf_wdata_o, 0);

        idle();
        rst_n_i = 1'b1;
        tick();
        check("post_rst_wen",    rf_wen_o, 0);
        check("post_rst_stall0", stall0_cnt_o, 0);
        check("post_rst_stall1", stall1_cnt_o, 0);

        // ---- Single requester 0 ----
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        settle();
        check("single_ready0", req0_ready_o, 1);
        check("single_ready1", req1_ready_o, 0);
        tick();
        idle();
        check("single_wen",   rf_wen_o, 1);
        check("single_waddr", rf_waddr_o, 5);
        check("single_wdata", rf_wdata_o, 32'hDEADBEEF);
        tick();
        check("single_wen_drop",   rf_wen_o, 0);
        check("single_waddr_hold", rf_waddr_o, 5);
        check("single_wdata_hold", rf_wdata_o, 32'hDEADBEEF);

        // ---- Single requester 1 (leaves last_grant = 1) ----
        drive(1'b0, '0, '0, 1'b1, 5'd9, 32'h99);
        settle();
        check("lsu_ready1", req1_ready_o, 1);
        tick();
        idle();
        check("lsu_waddr", rf_waddr_o, 9);
        check("lsu_wdata", rf_wdata_o, 32'h99);

        // ---- Contention for 4 cycles: grants 0,1,0,1 ----
        exp_grant_seq = 4'b1010; // bit k = index granted in cycle k
        drive(1'b1, 5'd3, 32'h3333, 1'b1, 5'd4, 32'h4444);
        for (int k = 0; k < 4; k++) begin
            settle();
            check($sformatf("cont_ready0_c%0d", k), req0_ready_o, !exp_grant_seq[k]);
            check($sformatf("cont_ready1_c%0d", k), req1_ready_o,  exp_grant_seq[k]);
            tick();
            check($sformatf("cont_waddr_c%0d", k), rf_waddr_o, exp_grant_seq[k] ? 5'd4 : 5'd3);
        end
        idle();
        check("cont_stall0", stall0_cnt_o, 2);
        check("cont_stall1", stall1_cnt_o, 2);

        // ---- x0 write by requester 1: acked, write dropped ----
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234);
        settle();
        check("x0_ready1", req1_ready_o, 1);
        tick();
        idle();
        check("x0_wen",   rf_wen_o, 0);
        check("x0_wdata", rf_wdata_o, 32'h1234);
        // The x0 grant moved last_grant to 1, so a tie now goes to requester 0.
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        settle();
        check("x0_tie_ready0", req0_ready_o, 1);
        check("x0_tie_ready1", req1_ready_o, 0);
        tick();
        idle();
        check("x0_tie_waddr", rf_waddr_o, 3);
        check("x0_tie_stall1", stall1_cnt_o, 3);

        // ---- Same-address collision with last_grant = 1 ----
        drive(1'b0, '0, '0, 1'b1, 5'd8, 32'h8);
        tick();
        commit_rf();
        drive(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
        tick();
        commit_rf();
        check("coll_first_wen",   rf_wen_o, 1);
        check("coll_first_wdata", rf_wdata_o, 32'hA);
        check("coll_x7_first",    rf_model[7], 32'hA);
        drive(1'b0, '0, '0, 1'b1, 5'd7, 32'hB);
        tick();
        commit_rf();
        idle();
        check("coll_second_wdata", rf_wdata_o, 32'hB);
        check("coll_x7_final",     rf_model[7], 32'hB);
        check("coll_x8",           rf_model[8], 32'h8);

        // ---- Clear, then sustained contention to saturation ----
        stall_clr_i = 1'b1;
        tick();
        stall_clr_i = 1'b0;
        check("clr_idle_stall0", stall0_cnt_o, 0);
        check("clr_idle_stall1", stall1_cnt_o, 0);
        // last_grant = 1 here; one requester stalls every cycle, alternating.
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        for (int k = 0; k < 10; k++) tick();
        check("sat_mid_stall0", stall0_cnt_o, 5);
        check("sat_mid_stall1", stall1_cnt_o, 5);
        for (int k = 0; k < 510; k++) tick();
        check("sat_stall0", stall0_cnt_o, 255);
        check("sat_stall1", stall1_cnt_o, 255);
        // Clear while a stall is happening: clear wins.
        stall_clr_i = 1'b1;
        tick();
        stall_clr_i = 1'b0;
        check("clr_busy_stall0", stall0_cnt_o, 0);
        check("clr_busy_stall1", stall1_cnt_o, 0);
        tick();
        check("after_clr_stall0", stall0_cnt_o, 1);
        check("after_clr_stall1", stall1_cnt_o, 0);
        idle();
        tick();

        // ---- Reset mid-operation discards the captured write ----
        drive(1'b1, 5'd6, 32'h66, 1'b0, '0, '0);
        rst_n_i = 1'b0;
        settle();
        check("midrst_ready0", req0_ready_o, 0);
        tick();
        check("midrst_wen",   rf_wen_o, 0);
        check("midrst_waddr", rf_waddr_o, 0);
        check("midrst_wdata", rf_wdata_o, 0);
        idle();
        rst_n_i = 1'b1;
        tick();
        check("midrst_after_wen", rf_wen_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rf_write_arbiter
